handshake_packer: RTL and testbench

- Parametrised word-packing device with bus-request/grant handshake. Collects NUM_WORDS words of WORD_W bits through a valid/ready input port into a packed buffer.
- Once full: requests the shared bus, waits for grant, then presents the packed frame until the consumer accepts it.
- Sits between a word producer and the bus arbiter/consumer pair. Generalises the fixed 4x16 device with configurable width, depth and run mode, plus input back-pressure.

---
 rtl/handshake_packer_pkg.sv | 18 +
 rtl/handshake_packer_if.sv | 33 +++
 rtl/packer_word_counter.sv | 27 ++
 rtl/handshake_packer.sv | 117 +++++++++++
 tb/tb_handshake_packer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/handshake_packer_pkg.sv
// Shared types and helpers for the handshake_packer word-packing block.
// State encodings are fixed so legacy tools and debug scripts can decode them.
package handshake_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_REQ     = 3'd2,
    ST_HOLD    = 3'd3,
    ST_BACKOFF = 3'd4
  } state_t;

  // Counter width for a count range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/handshake_packer_if.sv
// Producer / bus / consumer signal bundle for handshake_packer.
// The packer connects through the slave modport, its environment through master.
interface handshake_packer_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
);
  import handshake_packer_pkg::*;

  localparam int CNT_W = cnt_w(NUM_WORDS);

  logic                          start;
  logic                          in_valid;
  logic [WORD_W-1:0]             in_data;
  logic                          in_ready;
  logic                          req;
  logic                          gnt;
  logic                          out_valid;
  logic [NUM_WORDS*WORD_W-1:0]   out_data;
  logic                          accepted;
  logic [CNT_W-1:0]              word_count;
  logic                          gnt_timeout;

  modport slave (
    input  start, in_valid, in_data, gnt, accepted,
    output in_ready, req, out_valid, out_data, word_count, gnt_timeout
  );

  modport master (
    output start, in_valid, in_data, gnt, accepted,
    input  in_ready, req, out_valid, out_data, word_count, gnt_timeout
  );

endinterface

// File: rtl/packer_word_counter.sv
// Enabled up-counter that wraps to zero after TERMINAL and flags the terminal value.
// A synchronous clear takes priority over counting.
module packer_word_counter #(
  parameter int WIDTH    = 2,
  parameter int TERMINAL = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  assign terminal = (count == WIDTH'(TERMINAL));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/handshake_packer.sv
// Packs NUM_WORDS input words into one frame, then requests the bus and holds the frame.
// Optional grant back-off is enabled by defining HANDSHAKE_PACKER_TIMEOUT_EN.
module handshake_packer
  import handshake_packer_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 4,
  parameter int CONTINUOUS  = 1,
  parameter int GNT_TIMEOUT = 8
) (
  input logic               clock,
  input logic               reset,
  handshake_packer_if.slave bus
);

  localparam int CNT_W = cnt_w(NUM_WORDS);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] COLLECT = ST_COLLECT;
  localparam logic [2:0] REQ     = ST_REQ;
  localparam logic [2:0] HOLD    = ST_HOLD;
  localparam logic [2:0] BACKOFF = ST_BACKOFF;

  if (WORD_W < 1 || NUM_WORDS < 2 || GNT_TIMEOUT < 2) begin : g_bad_params
    $error("handshake_packer: illegal parameter values");
  end

  logic [2:0]                    state;
  logic [2:0]                    state_next;
  logic [NUM_WORDS-1:0][WORD_W-1:0] buffer;
  logic [CNT_W-1:0]              word_count;
  logic                          word_last;
  logic                          accept;
  logic                          timeout_expired;

  assign accept = bus.in_valid && (state == COLLECT);

  packer_word_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (NUM_WORDS - 1)
  ) u_word_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (1'b0),
    .enable   (accept),
    .count    (word_count),
    .terminal (word_last)
  );

`ifdef HANDSHAKE_PACKER_TIMEOUT_EN
  localparam int TO_W = cnt_w(GNT_TIMEOUT);

  logic [TO_W-1:0] timeout_count_unused;

  // Counts REQ cycles; leaving REQ (grant or back-off) restarts it from zero.
  packer_word_counter #(
    .WIDTH    (TO_W),
    .TERMINAL (GNT_TIMEOUT - 1)
  ) u_timeout_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != REQ),
    .enable   (state == REQ),
    .count    (timeout_count_unused),
    .terminal (timeout_expired)
  );

  assign bus.gnt_timeout = (state == BACKOFF);
`else
  assign timeout_expired = 1'b0;
  assign bus.gnt_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A grant sampled on the expiry cycle wins over back-off.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COLLECT;
      COLLECT: if (accept && word_last) state_next = REQ;
      REQ: begin
        if (bus.gnt) begin
          state_next = HOLD;
        end else if (timeout_expired) begin
          state_next = BACKOFF;
        end
      end
      HOLD:    if (bus.accepted) state_next = (CONTINUOUS != 0) ? COLLECT : IDLE;
`ifdef HANDSHAKE_PACKER_TIMEOUT_EN
      BACKOFF: state_next = REQ;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buffer <= '0;
    end else if (accept) begin
      buffer[word_count] <= bus.in_data;
    end
  end

  assign bus.in_ready   = (state == COLLECT);
  assign bus.req        = (state == REQ);
  assign bus.out_valid  = (state == HOLD);
  assign bus.out_data   = buffer;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_handshake_packer.sv
// Directed, table-driven bench for handshake_packer (4 x 16-bit words).
// Covers both run modes; timeout checks follow HANDSHAKE_PACKER_TIMEOUT_EN.
module tb_handshake_packer;
  import handshake_packer_pkg::*;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        gnt;
    logic        accepted;
    logic        exp_in_ready;
    logic        exp_req;
    logic        exp_out_valid;
    logic [1:0]  exp_word_count;
    logic [63:0] exp_out_data;
  } vec_t;

  localparam int NUM_VECS = 19;

  logic clock = 1'b0;
  logic reset;
  int   num_checks = 0;
  int   num_fails  = 0;
  vec_t vecs [NUM_VECS];

  always #5 clock = ~clock;

  handshake_packer_if #(.WORD_W(16), .NUM_WORDS(4)) bus_c ();
  handshake_packer_if #(.WORD_W(16), .NUM_WORDS(4)) bus_n ();

  handshake_packer #(
    .WORD_W(16), .NUM_WORDS(4), .CONTINUOUS(1), .GNT_TIMEOUT(8)
  ) dut_c (
    .clock (clock),
    .reset (reset),
    .bus   (bus_c.slave)
  );

  handshake_packer #(
    .WORD_W(16), .NUM_WORDS(4), .CONTINUOUS(0), .GNT_TIMEOUT(8)
  ) dut_n (
    .clock (clock),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkDut(input string tag, input logic ir, input logic rq, input logic ov,
                          input logic [1:0] wc, input logic [63:0] od);
    checkOutput({tag, ".in_ready"},   64'(bus_c.in_ready),   64'(ir));
    checkOutput({tag, ".req"},        64'(bus_c.req),        64'(rq));
    checkOutput({tag, ".out_valid"},  64'(bus_c.out_valid),  64'(ov));
    checkOutput({tag, ".word_count"}, 64'(bus_c.word_count), 64'(wc));
    checkOutput({tag, ".out_data"},   bus_c.out_data,        od);
  endtask

  // Drive dut_c inputs, then let one clock edge pass and settle.
  task automatic applyStimulus(input logic s, input logic v, input logic [15:0] d,
                               input logic g, input logic a);
    bus_c.start    = s;
    bus_c.in_valid = v;
    bus_c.in_data  = d;
    bus_c.gnt      = g;
    bus_c.accepted = a;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulusN(input logic s, input logic v, input logic [15:0] d,
                                input logic g, input logic a);
    bus_n.start    = s;
    bus_n.in_valid = v;
    bus_n.in_data  = d;
    bus_n.gnt      = g;
    bus_n.accepted = a;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 64'h0000_0000_0000_1111};
    vecs[2]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h0000_0000_2222_1111};
    vecs[3]  = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 64'h0000_3333_2222_1111};
    vecs[4]  = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 64'h4444_3333_2222_1111};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 64'h4444_3333_2222_1111};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 64'h4444_3333_2222_1111};
    vecs[7]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 64'h4444_3333_2222_1111};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'h4444_3333_2222_1111};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 64'h4444_3333_2222_1111};
    vecs[10] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 64'h4444_3333_2222_AAAA};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 64'h4444_3333_2222_AAAA};
    vecs[12] = '{1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h4444_3333_BBBB_AAAA};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h4444_3333_BBBB_AAAA};
    vecs[14] = '{1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 64'h4444_CCCC_BBBB_AAAA};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 64'h4444_CCCC_BBBB_AAAA};
    vecs[16] = '{1'b0, 1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 64'hDDDD_CCCC_BBBB_AAAA};
    vecs[17] = '{1'b0, 1'b1, 16'hEEEE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 64'hDDDD_CCCC_BBBB_AAAA};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'hDDDD_CCCC_BBBB_AAAA};

    reset = 1'b1;
    bus_c.start = 1'b0; bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.gnt = 1'b0; bus_c.accepted = 1'b0;
    bus_n.start = 1'b0; bus_n.in_valid = 1'b0; bus_n.in_data = '0; bus_n.gnt = 1'b0; bus_n.accepted = 1'b0;
    #12;
    checkDut("reset", 1'b0, 1'b0, 1'b0, 2'd0, 64'h0);
    checkOutput("reset.gnt_timeout", 64'(bus_c.gnt_timeout), 64'h0);
    checkOutput("reset_n.in_ready", 64'(bus_n.in_ready), 64'h0);
    checkOutput("reset_n.out_data", bus_n.out_data, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].start, vecs[i].in_valid, vecs[i].in_data, vecs[i].gnt, vecs[i].accepted);
      checkDut($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_req,
               vecs[i].exp_out_valid, vecs[i].exp_word_count, vecs[i].exp_out_data);
    end

    // Long hold: frame must stay put and input must stay blocked.
    for (int w = 1; w <= 4; w++) applyStimulus(1'b0, 1'b1, 16'(w), 1'b0, 1'b0);
    checkDut("hold.req", 1'b0, 1'b1, 1'b0, 2'd0, 64'h0004_0003_0002_0001);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      checkDut($sformatf("hold%0d", c), 1'b0, 1'b0, 1'b1, 2'd0, 64'h0004_0003_0002_0001);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkDut("hold.accept", 1'b1, 1'b0, 1'b0, 2'd0, 64'h0004_0003_0002_0001);

    // Reset in the middle of a frame discards it immediately.
    applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h6666, 1'b0, 1'b0);
    checkDut("midrst.pre", 1'b1, 1'b0, 1'b0, 2'd2, 64'h0004_0003_6666_5555);
    bus_c.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checkDut("midrst.async", 1'b0, 1'b0, 1'b0, 2'd0, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hDEF0, 1'b0, 1'b0);
    checkDut("midrst.req", 1'b0, 1'b1, 1'b0, 2'd0, 64'hDEF0_9ABC_5678_1234);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checkDut("midrst.hold", 1'b0, 1'b0, 1'b1, 2'd0, 64'hDEF0_9ABC_5678_1234);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Single-shot mode returns to IDLE and waits for start.
    applyStimulusN(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) applyStimulusN(1'b0, 1'b1, 16'(16'hA0 + w), 1'b0, 1'b0);
    checkOutput("oneshot.req", 64'(bus_n.req), 64'h1);
    applyStimulusN(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("oneshot.out_valid", 64'(bus_n.out_valid), 64'h1);
    checkOutput("oneshot.out_data", bus_n.out_data, 64'h00A3_00A2_00A1_00A0);
    applyStimulusN(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulusN(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
      checkOutput($sformatf("oneshot.idle%0d.in_ready", c), 64'(bus_n.in_ready), 64'h0);
      checkOutput($sformatf("oneshot.idle%0d.out_valid", c), 64'(bus_n.out_valid), 64'h0);
      checkOutput($sformatf("oneshot.idle%0d.word_count", c), 64'(bus_n.word_count), 64'h0);
    end
    applyStimulusN(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("oneshot.restart.in_ready", 64'(bus_n.in_ready), 64'h1);

    // Grant wait: back-off pulses with the feature, endless REQ without it.
    for (int w = 0; w < 4; w++) applyStimulus(1'b0, 1'b1, 16'(16'hC0 + w), 1'b0, 1'b0);
    checkOutput("to.req1", 64'(bus_c.req), 64'h1);
`ifdef HANDSHAKE_PACKER_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("to.req%0d", c), 64'(bus_c.req), 64'h1);
      checkOutput($sformatf("to.pulse%0d", c), 64'(bus_c.gnt_timeout), 64'h0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("to.backoff.req", 64'(bus_c.req), 64'h0);
    checkOutput("to.backoff.pulse", 64'(bus_c.gnt_timeout), 64'h1);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("to.retry.req%0d", c), 64'(bus_c.req), 64'h1);
      checkOutput($sformatf("to.retry.pulse%0d", c), 64'(bus_c.gnt_timeout), 64'h0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("to.lastgnt.out_valid", 64'(bus_c.out_valid), 64'h1);
    checkOutput("to.lastgnt.pulse", 64'(bus_c.gnt_timeout), 64'h0);
`else
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("wait.req%0d", c), 64'(bus_c.req), 64'h1);
      checkOutput($sformatf("wait.pulse%0d", c), 64'(bus_c.gnt_timeout), 64'h0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("wait.gnt.out_valid", 64'(bus_c.out_valid), 64'h1);
`endif
    checkOutput("to.out_data", bus_c.out_data, 64'h00C3_00C2_00C1_00C0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
